// File: rtl/rvvi_ack_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvvi_ack_rx_pkg
//  Description : Shared beat-index constants and receive-FSM state type for
//                the rvvi host acknowledgement receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package rvvi_ack_rx_pkg;

    // Beat positions inside a 9-word acknowledgement frame.
    localparam logic [3:0] ACK_IDX_ETYPE    = 4'd3;
    localparam logic [3:0] ACK_IDX_CNT_LO   = 4'd4;
    localparam logic [3:0] ACK_IDX_CNT_HI   = 4'd5;
    localparam logic [3:0] ACK_IDX_MINST_LO = 4'd6;
    localparam logic [3:0] ACK_IDX_MINST_HI = 4'd7;
    localparam logic [3:0] ACK_IDX_LOAD     = 4'd8;
    localparam logic [3:0] ACK_LEN          = 4'd9;

    typedef enum logic [1:0] {
        ACK_IDLE   = 2'd0,
        ACK_RECV   = 2'd1,
        ACK_DRAIN  = 2'd2,
        ACK_COMMIT = 2'd3
    } AckRxStateType;

endpackage
`default_nettype wire

// File: rtl/rvvi_ack_window.sv
`default_nettype none
// ============================================================================
//  Module      : rvvi_ack_window
//  Description : Outstanding-frame bookkeeping for the ack path: sent count,
//                next expected ack, lost-ack counting, timeout resync and the
//                registered stall request to the tracer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvvi_ack_window #(
    parameter logic [31:0] WINDOW      = 32'd8,
    parameter logic [31:0] LOAD_THRESH = 32'hFFFF_FFFF,
    parameter logic [31:0] TIMEOUT     = 32'd100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_sent,
    input  logic        commit,
    input  logic [31:0] commit_count,
    input  logic [31:0] host_load_next,
    output logic        accept,
    output logic        timeout_now,
    output logic        timeout_pulse,
    output logic [31:0] missed_count,
    output logic        stall
);

    logic [31:0] sent_count;
    logic [31:0] next_expected;
    logic [31:0] timer;

    logic [31:0] sent_next;
    logic [31:0] outstanding;
    logic [31:0] ack_diff;
    logic [31:0] expected_next;
    logic [31:0] miss_add;
    logic [32:0] miss_sum;
    logic [31:0] missed_next;
    logic [31:0] timer_next;
    logic [31:0] outstanding_next;

    // Accept/timeout decisions and the next values of all window state.
    always_comb begin
        sent_next   = sent_count + {31'd0, frame_sent};
        outstanding = sent_count - next_expected;
        // In-order or ahead-of-expected acks lie in the lower half of the
        // 32-bit circle; anything in the upper half is stale or duplicated.
        ack_diff    = commit_count - next_expected;
        accept      = commit & ~ack_diff[31];
        timeout_now = ~accept & (outstanding != 32'd0) & (timer == TIMEOUT - 32'd1);

        expected_next = next_expected;
        miss_add      = 32'd0;
        if (accept) begin
            expected_next = commit_count + 32'd1;
            miss_add      = ack_diff;
        end else if (timeout_now) begin
            expected_next = sent_next;
            miss_add      = sent_next - next_expected;
        end

        miss_sum    = {1'b0, missed_count} + {1'b0, miss_add};
        missed_next = miss_sum[32] ? 32'hFFFF_FFFF : miss_sum[31:0];

        if (accept || timeout_now || outstanding == 32'd0) begin
            timer_next = 32'd0;
        end else begin
            timer_next = timer + 32'd1;
        end

        outstanding_next = sent_next - expected_next;
    end

    // Window state, lost-ack counter, timeout pulse and registered stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_count    <= 32'd0;
            next_expected <= 32'd0;
            timer         <= 32'd0;
            missed_count  <= 32'd0;
            timeout_pulse <= 1'b0;
            stall         <= 1'b0;
        end else begin
            sent_count    <= sent_next;
            next_expected <= expected_next;
            timer         <= timer_next;
            missed_count  <= missed_next;
            timeout_pulse <= timeout_now;
            stall         <= (outstanding_next >= WINDOW) | (host_load_next >= LOAD_THRESH);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvvi_ack_rx.sv
`default_nettype none
// ============================================================================
//  Module      : rvvi_ack_rx
//  Description : Receives host acknowledgement frames from the MAC RX stream,
//                validates length and ethertype, commits in-order acks and
//                drives flow control back to the trace source.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvvi_ack_rx
    import rvvi_ack_rx_pkg::*;
#(
    parameter logic [15:0] ETHER_TYPE  = 16'h005C,
    parameter logic [31:0] WINDOW      = 32'd8,
    parameter logic [31:0] LOAD_THRESH = 32'hFFFF_FFFF,
    parameter logic [31:0] TIMEOUT     = 32'd100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] RxTdata,
    input  logic [3:0]  RxTkeep,
    input  logic        RxTvalid,
    input  logic        RxTlast,
    output logic        RxTready,
    input  logic        TxFrameSent,
    output logic        ExternalStall,
    output logic        AckValid,
    output logic [63:0] AckFrameCount,
    output logic [63:0] AckMinstret,
    output logic [31:0] HostLoad,
    output logic        BadFrame,
    output logic        AckTimeout,
    output logic [31:0] MissedCount
);

    AckRxStateType state, state_next;
    logic [3:0]    idx, idx_next;
    logic          bad_now;
    logic          commit;
    logic          accept;
    logic          timeout_now;
    logic [31:0]   load_next;

    logic [31:0] sh_cnt_lo, sh_cnt_hi, sh_min_lo, sh_min_hi, sh_load;

    // Byte enables carry no information for fixed-size ack frames.
    logic unused_keep;
    assign unused_keep = ^RxTkeep;

    // The block never backpressures once out of reset.
    assign RxTready = ~reset;
    assign commit   = (state == ACK_COMMIT);

    // Frame-parsing next state; a beat arriving in COMMIT starts a new frame.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        bad_now    = 1'b0;
        case (state)
            ACK_IDLE, ACK_COMMIT: begin
                state_next = ACK_IDLE;
                if (RxTvalid) begin
                    if (RxTlast) begin
                        bad_now = 1'b1;
                    end else begin
                        state_next = ACK_RECV;
                        idx_next   = 4'd1;
                    end
                end
            end
            ACK_RECV: begin
                if (RxTvalid) begin
                    if (idx == ACK_IDX_ETYPE && RxTdata[15:0] != ETHER_TYPE) begin
                        if (RxTlast) begin
                            state_next = ACK_IDLE;
                            bad_now    = 1'b1;
                        end else begin
                            state_next = ACK_DRAIN;
                        end
                    end else if (idx == ACK_LEN - 4'd1) begin
                        state_next = RxTlast ? ACK_COMMIT : ACK_DRAIN;
                    end else if (RxTlast) begin
                        state_next = ACK_IDLE;
                        bad_now    = 1'b1;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            ACK_DRAIN: begin
                if (RxTvalid && RxTlast) begin
                    state_next = ACK_IDLE;
                    bad_now    = 1'b1;
                end
            end
            default: state_next = ACK_IDLE;
        endcase
    end

    // FSM state and beat index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACK_IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Shadow copy of the payload beats; only committed acks reach the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_cnt_lo <= 32'd0;
            sh_cnt_hi <= 32'd0;
            sh_min_lo <= 32'd0;
            sh_min_hi <= 32'd0;
            sh_load   <= 32'd0;
        end else if (state == ACK_RECV && RxTvalid) begin
            case (idx)
                ACK_IDX_CNT_LO:   sh_cnt_lo <= RxTdata;
                ACK_IDX_CNT_HI:   sh_cnt_hi <= RxTdata;
                ACK_IDX_MINST_LO: sh_min_lo <= RxTdata;
                ACK_IDX_MINST_HI: sh_min_hi <= RxTdata;
                ACK_IDX_LOAD:     sh_load   <= RxTdata;
                default: ;
            endcase
        end
    end

    // A timeout forgets the host's last load report.
    assign load_next = accept ? sh_load : (timeout_now ? 32'd0 : HostLoad);

    // Committed ack outputs and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            AckValid      <= 1'b0;
            BadFrame      <= 1'b0;
            AckFrameCount <= 64'd0;
            AckMinstret   <= 64'd0;
            HostLoad      <= 32'd0;
        end else begin
            AckValid <= accept;
            BadFrame <= bad_now;
            HostLoad <= load_next;
            if (accept) begin
                AckFrameCount <= {sh_cnt_hi, sh_cnt_lo};
                AckMinstret   <= {sh_min_hi, sh_min_lo};
            end
        end
    end

    rvvi_ack_window #(
        .WINDOW      (WINDOW),
        .LOAD_THRESH (LOAD_THRESH),
        .TIMEOUT     (TIMEOUT)
    ) u_window (
        .clk            (clk),
        .reset          (reset),
        .frame_sent     (TxFrameSent),
        .commit         (commit),
        .commit_count   (sh_cnt_lo),
        .host_load_next (load_next),
        .accept         (accept),
        .timeout_now    (timeout_now),
        .timeout_pulse  (AckTimeout),
        .missed_count   (MissedCount),
        .stall          (ExternalStall)
    );

endmodule
`default_nettype wire

// File: tb/tb_rvvi_ack_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvvi_ack_rx
//  Description : Scoreboard bench for rvvi_ack_rx: directed ack frames with
//                hand-computed expected acks, bad frames and timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvvi_ack_rx;

    localparam logic [15:0] ET  = 16'h005C;
    localparam int          TMO = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RxTdata;
    logic [3:0]  RxTkeep;
    logic        RxTvalid;
    logic        RxTlast;
    logic        RxTready;
    logic        TxFrameSent;
    logic        ExternalStall;
    logic        AckValid;
    logic [63:0] AckFrameCount;
    logic [63:0] AckMinstret;
    logic [31:0] HostLoad;
    logic        BadFrame;
    logic        AckTimeout;
    logic [31:0] MissedCount;

    rvvi_ack_rx #(
        .ETHER_TYPE  (ET),
        .WINDOW      (32'd8),
        .LOAD_THRESH (32'hFFFF_FFFF),
        .TIMEOUT     (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .RxTdata       (RxTdata),
        .RxTkeep       (RxTkeep),
        .RxTvalid      (RxTvalid),
        .RxTlast       (RxTlast),
        .RxTready      (RxTready),
        .TxFrameSent   (TxFrameSent),
        .ExternalStall (ExternalStall),
        .AckValid      (AckValid),
        .AckFrameCount (AckFrameCount),
        .AckMinstret   (AckMinstret),
        .HostLoad      (HostLoad),
        .BadFrame      (BadFrame),
        .AckTimeout    (AckTimeout),
        .MissedCount   (MissedCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] cnt;
        logic [63:0] mi;
        logic [31:0] ld;
        logic [31:0] missed;
    } exp_t;

    exp_t sb[$];
    int checks  = 0;
    int errors  = 0;
    int bad_seen = 0;
    int bad_exp  = 0;
    int tmo_seen = 0;
    int tmo_exp  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every committed ack is popped from the scoreboard and compared.
    always @(negedge clk) begin
        exp_t e;
        if (BadFrame === 1'b1) bad_seen++;
        if (AckTimeout === 1'b1) tmo_seen++;
        if (AckValid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got count %0h expected no ack", AckFrameCount);
            end else begin
                e = sb.pop_front();
                check("ack_count",   AckFrameCount, e.cnt);
                check("ack_minstret", AckMinstret,  e.mi);
                check("ack_load",    {32'd0, HostLoad},    {32'd0, e.ld});
                check("ack_missed",  {32'd0, MissedCount}, {32'd0, e.missed});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] cnt, input logic [63:0] mi,
                        input logic [31:0] ld, input logic [31:0] missed);
        exp_t e;
        e.cnt = cnt; e.mi = mi; e.ld = ld; e.missed = missed;
        sb.push_back(e);
    endtask

    task automatic tx(input int n);
        repeat (n) begin
            TxFrameSent = 1'b1;
            tick(1);
        end
        TxFrameSent = 1'b0;
        tick(1);
    endtask

    task automatic send_frame(input logic [63:0] cnt, input logic [63:0] mi,
                              input logic [31:0] ld, input logic [15:0] et, input int nb);
        logic [31:0] w;
        for (int i = 0; i < nb; i++) begin
            case (i)
                0: w = 32'hFFFF_FFFF;
                1: w = 32'h0011_2233;
                2: w = 32'h4455_6677;
                3: w = {16'hABCD, et};
                4: w = cnt[31:0];
                5: w = cnt[63:32];
                6: w = mi[31:0];
                7: w = mi[63:32];
                default: w = ld;
            endcase
            RxTdata  = w;
            RxTkeep  = 4'hF;
            RxTvalid = 1'b1;
            RxTlast  = (i == nb - 1);
            tick(1);
        end
        RxTvalid = 1'b0;
        RxTlast  = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        RxTvalid    = 1'b0;
        RxTlast     = 1'b0;
        TxFrameSent = 1'b0;
        reset       = 1'b1;
        tick(2);
        @(negedge clk);
        check("rst_ready",   {63'd0, RxTready},      64'd0);
        check("rst_stall",   {63'd0, ExternalStall}, 64'd0);
        check("rst_valid",   {63'd0, AckValid},      64'd0);
        check("rst_count",   AckFrameCount,          64'd0);
        check("rst_minst",   AckMinstret,            64'd0);
        check("rst_load",    {32'd0, HostLoad},      64'd0);
        check("rst_missed",  {32'd0, MissedCount},   64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        RxTdata = 32'd0; RxTkeep = 4'd0; RxTvalid = 1'b0; RxTlast = 1'b0;
        TxFrameSent = 1'b0; reset = 1'b1;
        tick(1);
        do_reset();
        @(negedge clk);
        check("ready_after_rst", {63'd0, RxTready}, 64'd1);

        // Three in-order acks.
        tx(3);
        push(64'd0, 64'd10, 32'd5, 32'd0); send_frame(64'd0, 64'd10, 32'd5, ET, 9);
        push(64'd1, 64'd20, 32'd6, 32'd0); send_frame(64'd1, 64'd20, 32'd6, ET, 9);
        push(64'd2, 64'd30, 32'd7, 32'd0); send_frame(64'd2, 64'd30, 32'd7, ET, 9);
        @(negedge clk);
        check("t1_minst",  AckMinstret,          64'd30);
        check("t1_missed", {32'd0, MissedCount}, 64'd0);
        check("t1_stall",  {63'd0, ExternalStall}, 64'd0);
        check("t1_sb",     64'(sb.size()),       64'd0);
        // Nothing outstanding, so no timeout may fire.
        tick(TMO + 20);
        @(negedge clk);
        check("t1_no_timeout", 64'(tmo_seen), 64'(tmo_exp));

        // Window full stalls; one ack releases.
        do_reset();
        tx(8);
        tick(2);
        @(negedge clk);
        check("t2_stall_full", {63'd0, ExternalStall}, 64'd1);
        push(64'd0, 64'd100, 32'd1, 32'd0); send_frame(64'd0, 64'd100, 32'd1, ET, 9);
        @(negedge clk);
        check("t2_stall_rel", {63'd0, ExternalStall}, 64'd0);

        // Sequence gap, stale ack, then next-expected ack.
        do_reset();
        tx(5);
        push(64'd0, 64'd11, 32'd2, 32'd0); send_frame(64'd0, 64'd11, 32'd2, ET, 9);
        push(64'd3, 64'd33, 32'd3, 32'd2); send_frame(64'd3, 64'd33, 32'd3, ET, 9);
        send_frame(64'd1, 64'd99, 32'd9, ET, 9);
        @(negedge clk);
        check("t3_dup_count", AckFrameCount,       64'd3);
        check("t3_dup_load",  {32'd0, HostLoad},   64'd3);
        push(64'h0000_0001_0000_0004, 64'h0000_0002_0000_002C, 32'd4, 32'd2);
        send_frame(64'h0000_0001_0000_0004, 64'h0000_0002_0000_002C, 32'd4, ET, 9);

        // Bad ethertype, short frame, single-beat frame.
        bad_exp += 3;
        send_frame(64'd5, 64'd55, 32'd5, 16'h0800, 9);
        send_frame(64'd5, 64'd55, 32'd5, ET, 7);
        send_frame(64'd5, 64'd55, 32'd5, ET, 1);
        @(negedge clk);
        check("t4_bad_cnt", 64'(bad_seen),        64'(bad_exp));
        check("t4_count",   AckFrameCount,        64'h0000_0001_0000_0004);
        check("t4_minst",   AckMinstret,          64'h0000_0002_0000_002C);
        check("t4_load",    {32'd0, HostLoad},    64'd4);
        check("t4_missed",  {32'd0, MissedCount}, 64'd2);

        // Load stall, then timeout resync clears load and releases stall.
        do_reset();
        tx(1);
        push(64'd0, 64'd7, 32'hFFFF_FFFF, 32'd0); send_frame(64'd0, 64'd7, 32'hFFFF_FFFF, ET, 9);
        @(negedge clk);
        check("t5_load_stall", {63'd0, ExternalStall}, 64'd1);
        tx(2);
        tick(TMO - 20);
        @(negedge clk);
        check("t5_early_tmo", 64'(tmo_seen), 64'(tmo_exp));
        tmo_exp++;
        tick(40);
        @(negedge clk);
        check("t5_tmo",      64'(tmo_seen),          64'(tmo_exp));
        check("t5_missed",   {32'd0, MissedCount},   64'd2);
        check("t5_load",     {32'd0, HostLoad},      64'd0);
        check("t5_stall",    {63'd0, ExternalStall}, 64'd0);

        // Reset in the middle of a frame discards the partial frame.
        for (int i = 0; i < 4; i++) begin
            RxTdata = 32'h1000_0000 + i; RxTvalid = 1'b1; RxTlast = 1'b0;
            tick(1);
        end
        do_reset();
        tx(1);
        push(64'd0, 64'd1, 32'd2, 32'd0); send_frame(64'd0, 64'd1, 32'd2, ET, 9);
        @(negedge clk);
        check("t6_stall",   {63'd0, ExternalStall}, 64'd0);

        check("final_sb",   64'(sb.size()), 64'd0);
        check("final_bad",  64'(bad_seen),  64'(bad_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
